// File: rtl/nios_sys_oci_dct_pkg.sv
// Shared types and default geometry for the OCI debug-trace (DCT) capture controller.
// The OCI_DCT_DROP_EN build option is handled in nios_sys_nios2_processor_oci_dct_ctrl.
package nios_sys_oci_dct_pkg;

    typedef enum logic [1:0] {
        PACK  = 2'd0,
        FLUSH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } dct_state_t;

    localparam int DCT_FRAME_W         = 10;
    localparam int DCT_FRAMES_PER_WORD = 3;
    localparam int DCT_CNT_W           = 4;
    localparam int DCT_WORD_W          = DCT_FRAME_W * DCT_FRAMES_PER_WORD;

endpackage

// File: rtl/nios_sys_oci_dct_outreg.sv
// Single-entry valid/ready holding register for packed trace words.
// A new word may be loaded on the same edge the current one drains.
module nios_sys_oci_dct_outreg
    import nios_sys_oci_dct_pkg::*;
#(
    parameter int DATA_W = DCT_WORD_W,
    parameter int CNT_W  = DCT_CNT_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic [CNT_W-1:0]  load_frames,
    input  logic              tw_ready,
    output logic [DATA_W-1:0] tw_data,
    output logic [CNT_W-1:0]  tw_frames,
    output logic              tw_valid,
    output logic              free
);

    assign free = !tw_valid || tw_ready;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tw_data   <= '0;
            tw_frames <= '0;
            tw_valid  <= 1'b0;
        end else if (load) begin
            tw_data   <= load_data;
            tw_frames <= load_frames;
            tw_valid  <= 1'b1;
        end else if (tw_valid && tw_ready) begin
            tw_valid  <= 1'b0;
        end
    end

endmodule

// File: rtl/nios_sys_nios2_processor_oci_dct_ctrl.sv
// Trace-capture controller: packs trace frames into words, hands them to trace memory, flushes on test end.
// Build option OCI_DCT_DROP_EN: never back-pressure; frames that cannot be stored are counted in trc_drop_cnt.
module nios_sys_nios2_processor_oci_dct_ctrl
    import nios_sys_oci_dct_pkg::*;
#(
    parameter int FRAME_W         = DCT_FRAME_W,
    parameter int FRAMES_PER_WORD = DCT_FRAMES_PER_WORD,
    parameter int CNT_W           = DCT_CNT_W
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               trc_enable,
    input  logic [FRAME_W-1:0]                 trc_frame,
    input  logic                               trc_frame_valid,
    output logic                               trc_frame_ready,
    input  logic                               test_ending,
    output logic [FRAME_W*FRAMES_PER_WORD-1:0] dct_buffer,
    output logic [CNT_W-1:0]                   dct_count,
    output logic [FRAME_W*FRAMES_PER_WORD-1:0] tw_data,
    output logic [CNT_W-1:0]                   tw_frames,
    output logic                               tw_valid,
    input  logic                               tw_ready,
`ifdef OCI_DCT_DROP_EN
    output logic [15:0]                        trc_drop_cnt,
`endif
    output logic                               test_has_ended
);

    localparam int              WORD_W   = FRAME_W * FRAMES_PER_WORD;
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(FRAMES_PER_WORD - 1);
    localparam logic [CNT_W-1:0] FULL    = CNT_W'(FRAMES_PER_WORD);
    localparam logic [1:0]      ST_PACK  = PACK;
    localparam logic [1:0]      ST_FLUSH = FLUSH;
    localparam logic [1:0]      ST_DRAIN = DRAIN;
    localparam logic [1:0]      ST_DONE  = DONE;

    logic [1:0]        state;
    logic              out_free;
    logic              slot_last;
    logic              accept;
    logic              store;
    logic              complete;
    logic              flush_load;
    logic              load;
    logic [WORD_W-1:0] next_buf;
    logic [WORD_W-1:0] load_data;
    logic [CNT_W-1:0]  load_frames;

    assign slot_last = (dct_count == LAST);

`ifdef OCI_DCT_DROP_EN
    assign trc_frame_ready = (state == ST_PACK) && trc_enable;
`else
    assign trc_frame_ready = (state == ST_PACK) && trc_enable && !(slot_last && !out_free);
`endif

    // Under drop mode a ready-accepted frame may still find no room; store is what actually packs.
    assign accept     = trc_frame_valid && trc_frame_ready;
    assign store      = accept && (!slot_last || out_free);
    assign complete   = store && slot_last;
    assign flush_load = (state == ST_FLUSH) && (dct_count != '0) && out_free;
    assign load       = complete || flush_load;

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        next_buf = dct_buffer;
        for (int i = 0; i < FRAMES_PER_WORD; i++) begin
            if (dct_count == CNT_W'(i)) next_buf[i*FRAME_W +: FRAME_W] = trc_frame;
        end
    end

    assign load_data   = complete ? next_buf : dct_buffer;
    assign load_frames = complete ? FULL : dct_count;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            dct_buffer <= '0;
            dct_count  <= '0;
        end else if (load) begin
            dct_buffer <= '0;
            dct_count  <= '0;
        end else if (store) begin
            dct_buffer <= next_buf;
            dct_count  <= dct_count + 1'b1;
        end
    end

    // A frame accepted in the cycle test_ending is seen is packed before FLUSH evaluates the buffer.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= ST_PACK;
        end else begin
            case (state)
                ST_PACK:  if (test_ending) state <= ST_FLUSH;
                ST_FLUSH: if (dct_count == '0 || out_free) state <= ST_DRAIN;
                ST_DRAIN: if (!tw_valid) state <= ST_DONE;
                ST_DONE:  state <= ST_DONE;
                default:  state <= ST_PACK;
            endcase
        end
    end

    assign test_has_ended = (state == ST_DONE);

`ifdef OCI_DCT_DROP_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            trc_drop_cnt <= '0;
        end else if (accept && !store && trc_drop_cnt != 16'hFFFF) begin
            trc_drop_cnt <= trc_drop_cnt + 16'd1;
        end
    end
`endif

    nios_sys_oci_dct_outreg #(
        .DATA_W (WORD_W),
        .CNT_W  (CNT_W)
    ) u_outreg (
        .clk         (clk),
        .reset_n     (reset_n),
        .load        (load),
        .load_data   (load_data),
        .load_frames (load_frames),
        .tw_ready    (tw_ready),
        .tw_data     (tw_data),
        .tw_frames   (tw_frames),
        .tw_valid    (tw_valid),
        .free        (out_free)
    );

endmodule
